// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
// Merges the trail-pixel writes of two players into the single frame-buffer
// RAM write port. Each player has a small request FIFO, and one RAM write is
// granted per cycle, alternating between the players when both are waiting.
// After reset or a game restart, the whole frame buffer is swept to
// CLEAR_VALUE before player writes are accepted.
// Optional feature macro: FB_ARB_PLAYER_TAG_EN. When it is defined, every
// player write is ORed with an ownership tag: player 1 sets bit 0 and player 2
// sets the MSB. Clear writes are never tagged.
module fb_write_arbiter #(
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 8,
  parameter int                FB_PIXELS   = 307200,
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              reiniciar,
  input  logic              j1_wren,
  input  logic [ADDR_W-1:0] j1_addr,
  input  logic [DATA_W-1:0] j1_data,
  output logic              j1_ready,
  input  logic              j2_wren,
  input  logic [ADDR_W-1:0] j2_addr,
  input  logic [DATA_W-1:0] j2_data,
  output logic              j2_ready,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              clear_busy,
  output logic              overflow
);

  // FIFO pointers carry one extra wrap bit so that full and empty can be
  // told apart. FIFO_DEPTH must be a power of two and at least 2.
  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    LP_PONE = (PTR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_CONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(FB_PIXELS - 1);
  localparam logic [ADDR_W:0]   LP_PIX  = (ADDR_W+1)'(FB_PIXELS);
`ifdef FB_ARB_PLAYER_TAG_EN
  localparam logic [DATA_W-1:0] LP_TAG1 = DATA_W'(1);
  localparam logic [DATA_W-1:0] LP_TAG2 = DATA_W'(1) << (DATA_W - 1);
`endif

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_wren;
  logic [ADDR_W-1:0]   r_wraddress;
  logic [DATA_W-1:0]   r_data;
  logic                r_clear_busy;
  logic                r_overflow;
  logic                r_rr;          // 0: player 1 wins the next tie, 1: player 2
  logic [PTR_W:0]      r_wp [2];
  logic [PTR_W:0]      r_rp [2];
  logic [ADDR_W-1:0]   r_fa [2][FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fd [2][FIFO_DEPTH];

  logic                w_run;
  logic [1:0]          w_req;
  logic [ADDR_W-1:0]   w_addr [2];
  logic [DATA_W-1:0]   w_din  [2];
  logic [1:0]          w_empty;
  logic [1:0]          w_full;
  logic [1:0]          w_inrange;
  logic [1:0]          w_ready;
  logic [1:0]          w_push;
  logic [1:0]          w_drop;
  logic [1:0]          w_gnt;
  logic                w_sel;
  logic [ADDR_W-1:0]   w_pop_addr;
  logic [DATA_W-1:0]   w_pop_data;
  logic [DATA_W-1:0]   w_tag;

  assign w_run     = (r_state == S_RUN);
  assign w_req     = {j2_wren, j1_wren};
  assign w_addr[0] = j1_addr;
  assign w_addr[1] = j2_addr;
  assign w_din[0]  = j1_data;
  assign w_din[1]  = j2_data;

  assign j1_ready   = w_ready[0];
  assign j2_ready   = w_ready[1];
  assign wren       = r_wren;
  assign wraddress  = r_wraddress;
  assign data       = r_data;
  assign clear_busy = r_clear_busy;
  assign overflow   = r_overflow;

  // Per-player FIFO status, acceptance and loss detection. Ready looks only at
  // registered pointers, so a full FIFO refuses a push even while it pops.
  always_comb begin
    w_empty   = '0;
    w_full    = '0;
    w_inrange = '0;
    w_ready   = '0;
    w_push    = '0;
    w_drop    = '0;
    for (int p = 0; p < 2; p++) begin
      w_empty[p]   = (r_wp[p] == r_rp[p]);
      w_full[p]    = (r_wp[p][PTR_W] != r_rp[p][PTR_W]) &&
                     (r_wp[p][PTR_W-1:0] == r_rp[p][PTR_W-1:0]);
      w_inrange[p] = ({1'b0, w_addr[p]} < LP_PIX);
      w_ready[p]   = w_run && !w_full[p];
      w_push[p]    = w_req[p] && w_ready[p] && w_inrange[p];
      w_drop[p]    = w_run && w_req[p] && !(w_ready[p] && w_inrange[p]);
    end
  end

  // Round-robin grant: a tie goes to the pointed-at player; a lone waiter wins outright.
  always_comb begin
    w_gnt = 2'b00;
    if (w_run) begin
      if (!w_empty[0] && !w_empty[1]) begin
        w_gnt = r_rr ? 2'b10 : 2'b01;
      end else if (!w_empty[0]) begin
        w_gnt = 2'b01;
      end else if (!w_empty[1]) begin
        w_gnt = 2'b10;
      end
    end
    w_sel      = w_gnt[1];
    w_pop_addr = r_fa[w_sel][r_rp[w_sel][PTR_W-1:0]];
    w_pop_data = r_fd[w_sel][r_rp[w_sel][PTR_W-1:0]];
  end

`ifdef FB_ARB_PLAYER_TAG_EN
  assign w_tag = w_sel ? LP_TAG2 : LP_TAG1;
`else
  assign w_tag = '0;
`endif

  // FIFO storage; only the pointers need a reset, so the entries have none.
  always_ff @(posedge CLOCK_50) begin
    for (int p = 0; p < 2; p++) begin
      if (w_push[p]) begin
        r_fa[p][r_wp[p][PTR_W-1:0]] <= w_addr[p];
        r_fd[p][r_wp[p][PTR_W-1:0]] <= w_din[p];
      end
    end
  end

  // Control FSM: clear sweep, then arbitrated player writes; restart re-enters the sweep.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= S_CLEAR;
      r_cnt        <= '0;
      r_wren       <= 1'b0;
      r_wraddress  <= '0;
      r_data       <= '0;
      r_clear_busy <= 1'b1;
      r_overflow   <= 1'b0;
      r_rr         <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        r_wp[p] <= '0;
        r_rp[p] <= '0;
      end
    end else if (reiniciar) begin
      // Held restart parks the sweep at address 0 with the write port idle.
      r_state      <= S_CLEAR;
      r_cnt        <= '0;
      r_wren       <= 1'b0;
      r_clear_busy <= 1'b1;
      r_overflow   <= 1'b0;
      r_rr         <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        r_wp[p] <= '0;
        r_rp[p] <= '0;
      end
    end else if (r_state == S_CLEAR) begin
      r_wren      <= 1'b1;
      r_wraddress <= r_cnt;
      r_data      <= CLEAR_VALUE;
      if (r_cnt == LP_LAST) begin
        // The last clear write and the switch to RUN share this edge.
        r_state      <= S_RUN;
        r_clear_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + LP_CONE;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_push[p]) begin
          r_wp[p] <= r_wp[p] + LP_PONE;
        end
        if (w_gnt[p]) begin
          r_rp[p] <= r_rp[p] + LP_PONE;
        end
      end
      if (|w_drop) begin
        r_overflow <= 1'b1;
      end
      r_wren <= |w_gnt;
      if (|w_gnt) begin
        r_wraddress <= w_pop_addr;
        r_data      <= w_pop_data | w_tag;
      end
      // The pointer only moves when a tie was actually resolved.
      if (!w_empty[0] && !w_empty[1]) begin
        r_rr <= ~r_rr;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter with a small frame buffer. A queue
// model of the two FIFOs and the alternation rule predicts each RAM write and
// the cycle on which it must appear; a negedge monitor checks the write port.
module tb_fb_write_arbiter;
  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int N     = 64;
  localparam int DEPTH = 4;
  localparam logic [DW-1:0] CLR = 8'h00;
`ifdef FB_ARB_PLAYER_TAG_EN
  localparam logic [DW-1:0] TAG1 = 8'h01;
  localparam logic [DW-1:0] TAG2 = 8'h80;
`else
  localparam logic [DW-1:0] TAG1 = 8'h00;
  localparam logic [DW-1:0] TAG2 = 8'h00;
`endif

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] dat; } ent_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] dat; } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          reiniciar;
  logic          j1_wren, j2_wren;
  logic [AW-1:0] j1_addr, j2_addr;
  logic [DW-1:0] j1_data, j2_data;
  logic          j1_ready, j2_ready;
  logic          wren;
  logic [AW-1:0] wraddress;
  logic [DW-1:0] data;
  logic          clear_busy;
  logic          overflow;

  fb_write_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FB_PIXELS(N), .FIFO_DEPTH(DEPTH), .CLEAR_VALUE(CLR)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .reiniciar(reiniciar),
    .j1_wren(j1_wren), .j1_addr(j1_addr), .j1_data(j1_data), .j1_ready(j1_ready),
    .j2_wren(j2_wren), .j2_addr(j2_addr), .j2_data(j2_data), .j2_ready(j2_ready),
    .wren(wren), .wraddress(wraddress), .data(data),
    .clear_busy(clear_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // reference model state
  ent_t q1[$];
  ent_t q2[$];
  exp_t sb[$];
  bit   m_run;
  int   m_sweep;
  bit   m_ovf;
  bit   m_rr;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    sb.delete();
    m_run   = 1'b0;
    m_sweep = 0;
    m_ovf   = 1'b0;
    m_rr    = 1'b0;
  endtask

  task automatic chk_reset_vals();
    check(wren == 1'b0,       "rst_wren",       wren, 0);
    check(wraddress == '0,    "rst_wraddress",  wraddress, 0);
    check(data == '0,         "rst_data",       data, 0);
    check(overflow == 1'b0,   "rst_overflow",   overflow, 0);
    check(j1_ready == 1'b0,   "rst_j1_ready",   j1_ready, 0);
    check(j2_ready == 1'b0,   "rst_j2_ready",   j2_ready, 0);
    check(clear_busy == 1'b1, "rst_clear_busy", clear_busy, 1);
  endtask

  task automatic drive(input bit w1, input int a1, input int d1,
                       input bit w2, input int a2, input int d2);
    j1_wren = w1; j1_addr = AW'(a1); j1_data = DW'(d1);
    j2_wren = w2; j2_addr = AW'(a2); j2_data = DW'(d2);
  endtask

  // Check status outputs against the model, advance the model across the
  // coming clock edge, then wait for the following falling edge.
  task automatic step();
    bit   r1, r2, ne1, ne2;
    ent_t e;
    exp_t x;
    r1  = m_run && (q1.size() < DEPTH);
    r2  = m_run && (q2.size() < DEPTH);
    check(j1_ready == r1,        "j1_ready",   j1_ready, r1);
    check(j2_ready == r2,        "j2_ready",   j2_ready, r2);
    check(overflow == m_ovf,     "overflow",   overflow, m_ovf);
    check(clear_busy == !m_run,  "clear_busy", clear_busy, !m_run);
    if (reiniciar) begin
      q1.delete();
      q2.delete();
      m_ovf   = 1'b0;
      m_run   = 1'b0;
      m_sweep = 0;
      m_rr    = 1'b0;
    end else if (!m_run) begin
      x.cyc = cyc + 1; x.addr = AW'(m_sweep); x.dat = CLR;
      sb.push_back(x);
      m_sweep++;
      if (m_sweep == N) m_run = 1'b1;
    end else begin
      ne1 = (q1.size() > 0);
      ne2 = (q2.size() > 0);
      if (ne1 && (!ne2 || !m_rr)) begin
        e = q1.pop_front();
        x.cyc = cyc + 1; x.addr = e.addr; x.dat = e.dat | TAG1;
        sb.push_back(x);
        if (ne2) m_rr = 1'b1;
      end else if (ne2) begin
        e = q2.pop_front();
        x.cyc = cyc + 1; x.addr = e.addr; x.dat = e.dat | TAG2;
        sb.push_back(x);
        if (ne1) m_rr = 1'b0;
      end
      if (j1_wren) begin
        if (r1 && (int'(j1_addr) < N)) begin
          e.addr = j1_addr; e.dat = j1_data; q1.push_back(e);
        end else m_ovf = 1'b1;
      end
      if (j2_wren) begin
        if (r2 && (int'(j2_addr) < N)) begin
          e.addr = j2_addr; e.dat = j2_data; q2.push_back(e);
        end else m_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  // Monitor: every cycle, the write port must show exactly the predicted write (or none).
  always @(negedge clk) begin
    exp_t e;
    bit   exp_w;
    if (!reset) begin
      exp_w = (sb.size() > 0) && (sb[0].cyc == cyc);
      check(wren == exp_w, "wren", wren, exp_w);
      if (exp_w) begin
        e = sb.pop_front();
        if (wren) begin
          check(wraddress == e.addr, "wraddress", wraddress, e.addr);
          check(data == e.dat,       "data",      data, e.dat);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    reiniciar = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;

    // full sweep after reset release
    idle(N + 4);

    // single player-1 write
    drive(1, 10, 1, 0, 0, 0);
    step();
    idle(5);

    // both players push three entries in the same cycles
    for (int i = 0; i < 3; i++) begin
      drive(1, 20 + i, 8'h10 + i, 1, 40 + i, 8'h20 + i);
      step();
    end
    idle(8);

    // player 1 streams alone; the drain keeps pace
    for (int i = 0; i < 6; i++) begin
      drive(1, 30 + i, i, 0, 0, 0);
      step();
    end
    idle(4);
    check(overflow == 1'b0, "stream_no_overflow", overflow, 0);

    // both saturate until FIFOs fill and requests are lost
    for (int i = 0; i < 14; i++) begin
      drive(1, i, 8'h40 + i, 1, N - 1 - i, 8'h50 + i);
      step();
    end
    idle(12);
    check(overflow == 1'b1, "stall_overflow", overflow, 1);

    // restart pulse: overflow cleared, sweep from 0
    reiniciar = 1'b1;
    idle(1);
    reiniciar = 1'b0;
    idle(N + 3);

    // out-of-range address is discarded
    drive(1, N, 8'h33, 0, 0, 0);
    step();
    idle(4);
    check(overflow == 1'b1, "range_overflow", overflow, 1);

    // restart held several cycles, then reset mid-sweep
    reiniciar = 1'b1;
    idle(3);
    reiniciar = 1'b0;
    idle(20);
    #2 reset = 1'b1;
    model_reset();
    #1 chk_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    idle(N + 4);

    // player-2 write of zero data (tagged when the tag feature is built in)
    drive(0, 0, 0, 1, 5, 8'h00);
    step();
    idle(4);

    // random traffic with occasional bad addresses and restarts
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) != 0,
            ($urandom_range(0, 15) == 0) ? N + $urandom_range(0, 100) : $urandom_range(0, N - 1),
            $urandom_range(0, 255),
            $urandom_range(0, 2) != 0,
            ($urandom_range(0, 15) == 0) ? N + $urandom_range(0, 100) : $urandom_range(0, N - 1),
            $urandom_range(0, 255));
      reiniciar = ($urandom_range(0, 149) == 0);
      step();
    end
    reiniciar = 1'b0;
    idle(N + 10);
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
